// File: rtl/dryer_actuator_drv.sv
// Power-stage sequencer: turns motor/heat-level commands into interlocked motor and heater relay drive
// with spin-up, cool-down, slow heater PWM and a latched door/over-temperature fault.
module dryer_actuator_drv #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned SPINUP_S   = 2,
  parameter int unsigned COOLDOWN_S = 3,
  parameter int unsigned PWM_PERIOD = 8,
  parameter int unsigned LO_ON      = 3,
  parameter int unsigned MD_ON      = 5
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       MTR_CMD,
  input  logic [1:0] HTR_CMD,
  input  logic       DOOR_OPEN,
  input  logic       OVERTEMP,
  input  logic       CLR_FAULT,
  output logic       MOTOR_RELAY,
  output logic       HEAT_RELAY,
  output logic       FAULT,
  output logic [2:0] STATE_OUT
);

  localparam int unsigned T_MAX  = (SPINUP_S > COOLDOWN_S) ? SPINUP_S : COOLDOWN_S;
  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TCNT_W = $clog2(T_MAX + 1);
  localparam int unsigned PW     = $clog2(PWM_PERIOD + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] SPIN_T   = TCNT_W'(SPINUP_S);
  localparam logic [TCNT_W-1:0] COOL_T   = TCNT_W'(COOLDOWN_S);
  localparam logic [TCNT_W-1:0] TCNT_TOP = TCNT_W'(T_MAX);
  localparam logic [PW-1:0]     PWM_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [PW-1:0]     DUTY_LO  = PW'(LO_ON);
  localparam logic [PW-1:0]     DUTY_MD  = PW'(MD_ON);
  localparam logic [PW-1:0]     DUTY_HI  = PW'(PWM_PERIOD);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_SPINUP   = 3'd1,
    S_RUN      = 3'd2,
    S_COOLDOWN = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div, div_d;
  logic [TCNT_W-1:0] tick_cnt, tick_cnt_d, tcnt_inc;
  logic [PW-1:0]     pwm_cnt, pwm_d, duty, duty_d, duty_cmd;
  logic              heat_used, heat_used_d;
  logic              fault_spin, fault_spin_d;
  logic              motor_d, heat_d, fault_d;
  logic              tick, state_chg;

  assign STATE_OUT = state;

  always_comb begin
    tick     = (div == DIV_LAST);
    tcnt_inc = (tick && tick_cnt != TCNT_TOP) ? tick_cnt + 1'b1 : tick_cnt;

    case (HTR_CMD)
      2'b01:   duty_cmd = DUTY_LO;
      2'b10:   duty_cmd = DUTY_MD;
      2'b11:   duty_cmd = DUTY_HI;
      default: duty_cmd = '0;
    endcase

    state_d      = state;
    fault_spin_d = fault_spin;
    case (state)
      S_OFF: begin
        if (MTR_CMD && !DOOR_OPEN && !FAULT) state_d = S_SPINUP;
      end
      S_SPINUP, S_RUN, S_COOLDOWN: begin
        if (DOOR_OPEN) begin
          state_d      = S_FAULT;
          fault_spin_d = 1'b0;
        end else if (OVERTEMP) begin
          state_d      = S_FAULT;
          fault_spin_d = 1'b1;
        end else begin
          case (state)
            S_SPINUP: begin
              if (!MTR_CMD)                state_d = S_OFF;
              else if (tcnt_inc == SPIN_T) state_d = S_RUN;
            end
            S_RUN: begin
              if (!MTR_CMD) state_d = heat_used ? S_COOLDOWN : S_OFF;
            end
            default: begin
              if (MTR_CMD)                 state_d = S_RUN;
              else if (tcnt_inc == COOL_T) state_d = S_OFF;
            end
          endcase
        end
      end
      S_FAULT: begin
        if (DOOR_OPEN) fault_spin_d = 1'b0;
        if (CLR_FAULT && !MTR_CMD && !OVERTEMP && !DOOR_OPEN) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase

    // All timebases restart on any state change so each timed state begins at zero.
    state_chg  = (state_d != state);
    div_d      = (state_chg || tick) ? '0 : div + 1'b1;
    tick_cnt_d = state_chg ? '0 : tcnt_inc;

    if (state_chg)     pwm_d = '0;
    else if (tick)     pwm_d = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    else               pwm_d = pwm_cnt;

    // Duty only reloads at a period boundary so a mid-period level change cannot chatter the relay.
    duty_d = duty;
    if (state_d == S_RUN && (state_chg || (tick && pwm_cnt == PWM_LAST))) duty_d = duty_cmd;

    heat_d      = (state_d == S_RUN) && (pwm_d < duty_d);
    heat_used_d = (state_d == S_RUN) && (heat_used || heat_d);

    if (state_d == S_FAULT) fault_spin_d = fault_spin_d && (tick_cnt_d < COOL_T);
    else                    fault_spin_d = 1'b0;

    motor_d = (state_d == S_SPINUP) || (state_d == S_RUN) || (state_d == S_COOLDOWN) ||
              (state_d == S_FAULT && fault_spin_d);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_OFF;
      div         <= '0;
      tick_cnt    <= '0;
      pwm_cnt     <= '0;
      duty        <= '0;
      heat_used   <= 1'b0;
      fault_spin  <= 1'b0;
      MOTOR_RELAY <= 1'b0;
      HEAT_RELAY  <= 1'b0;
      FAULT       <= 1'b0;
    end else begin
      state       <= state_d;
      div         <= div_d;
      tick_cnt    <= tick_cnt_d;
      pwm_cnt     <= pwm_d;
      duty        <= duty_d;
      heat_used   <= heat_used_d;
      fault_spin  <= fault_spin_d;
      MOTOR_RELAY <= motor_d;
      HEAT_RELAY  <= heat_d;
      FAULT       <= fault_d;
    end
  end

endmodule

// File: tb/tb_dryer_actuator_drv.sv
// Randomised bench for dryer_actuator_drv against a cycle-count reference model of the sequencer rules.
module tb_dryer_actuator_drv;

  localparam int TD = 4;
  localparam int SP = 2;
  localparam int CD = 3;
  localparam int P  = 8;
  localparam int LO = 3;
  localparam int MD = 5;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       MTR_CMD;
  logic [1:0] HTR_CMD;
  logic       DOOR_OPEN;
  logic       OVERTEMP;
  logic       CLR_FAULT;
  logic       MOTOR_RELAY;
  logic       HEAT_RELAY;
  logic       FAULT;
  logic [2:0] STATE_OUT;

  dryer_actuator_drv #(
    .TICK_DIV  (TD),
    .SPINUP_S  (SP),
    .COOLDOWN_S(CD),
    .PWM_PERIOD(P),
    .LO_ON     (LO),
    .MD_ON     (MD)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .MTR_CMD    (MTR_CMD),
    .HTR_CMD    (HTR_CMD),
    .DOOR_OPEN  (DOOR_OPEN),
    .OVERTEMP   (OVERTEMP),
    .CLR_FAULT  (CLR_FAULT),
    .MOTOR_RELAY(MOTOR_RELAY),
    .HEAT_RELAY (HEAT_RELAY),
    .FAULT      (FAULT),
    .STATE_OUT  (STATE_OUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state code, edges since entry, latched duty in ticks, heat-used and fault-spin flags.
  int m_state, m_age, m_duty;
  bit m_used, m_spin;
  bit m_motor, m_heat, m_fault;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int level_ticks(input logic [1:0] lvl);
    case (lvl)
      2'b01:   return LO;
      2'b10:   return MD;
      2'b11:   return P;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_age = 0; m_duty = 0;
    m_used = 0; m_spin = 0;
    m_motor = 0; m_heat = 0; m_fault = 0;
  endtask

  task automatic model_step(input bit mtr, input logic [1:0] htr, input bit door, input bit ot, input bit clr);
    int ns, na;
    ns = m_state;
    na = m_age + 1;
    if (m_state >= 1 && m_state <= 3 && door) begin
      ns = 4; m_spin = 0;
    end else if (m_state >= 1 && m_state <= 3 && ot) begin
      ns = 4; m_spin = 1;
    end else begin
      case (m_state)
        0: if (mtr && !door) ns = 1;
        1: if (!mtr) ns = 0; else if (na == SP * TD) ns = 2;
        2: if (!mtr) ns = m_used ? 3 : 0;
        3: if (mtr) ns = 2; else if (na == CD * TD) ns = 0;
        4: begin
          if (door) m_spin = 0;
          if (clr && !mtr && !ot && !door) ns = 0;
        end
        default: ns = 0;
      endcase
    end
    if (ns != m_state) na = 0;

    m_heat = 0;
    if (ns == 2) begin
      if (na == 0) m_used = 0;
      if (na % (TD * P) == 0) m_duty = level_ticks(htr);
      m_heat = ((na / TD) % P) < m_duty;
      m_used = m_used | m_heat;
    end else begin
      m_used = 0;
    end
    if (ns != 4) m_spin = 0;

    m_motor = (ns >= 1 && ns <= 3) || (ns == 4 && m_spin && na < CD * TD);
    m_fault = (ns == 4);
    m_state = ns;
    m_age   = na;
  endtask

  task automatic compare_all();
    check_val("motor_relay", MOTOR_RELAY, m_motor);
    check_val("heat_relay", HEAT_RELAY, m_heat);
    check_val("fault", FAULT, m_fault);
    check_val("state_out", STATE_OUT, m_state);
    check_val("heat_needs_motor", HEAT_RELAY & ~MOTOR_RELAY, 0);
  endtask

  initial begin
    bit did_run_reset;
    bit rst_now;
    did_run_reset = 0;
    RESET_N   = 1'b0;
    MTR_CMD   = 1'b0;
    HTR_CMD   = 2'b00;
    DOOR_OPEN = 1'b0;
    OVERTEMP  = 1'b0;
    CLR_FAULT = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    compare_all();
    RESET_N = 1'b1;

    MTR_CMD = 1'b1;
    HTR_CMD = 2'b11;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (cyc > 40) begin
        if ($urandom % 70 == 0) MTR_CMD = ~MTR_CMD;
        if ($urandom % 30 == 0) HTR_CMD = 2'($urandom);
        if (DOOR_OPEN) begin
          if ($urandom % 15 == 0) DOOR_OPEN = 1'b0;
        end else if ($urandom % 300 == 0) DOOR_OPEN = 1'b1;
        if (OVERTEMP) begin
          if ($urandom % 30 == 0) OVERTEMP = 1'b0;
        end else if ($urandom % 250 == 0) OVERTEMP = 1'b1;
        CLR_FAULT = ($urandom % 6 == 0);
      end

      @(posedge CLK);
      model_step(MTR_CMD, HTR_CMD, DOOR_OPEN, OVERTEMP, CLR_FAULT);

      rst_now = (!did_run_reset && cyc > 2000 && m_state == 2 && m_age > 12) ||
                ($urandom % 2000 == 0);
      if (rst_now) begin
        did_run_reset = 1;
        #3 RESET_N = 1'b0;
        #1;
        model_reset();
        compare_all();
      end

      @(negedge CLK);
      RESET_N = 1'b1;
      compare_all();
    end

    check_val("mid_run_reset_seen", did_run_reset, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
